// File: rtl/idu_issue.sv
// RV64I decode-and-issue stage: decodes one instruction into ALU operands and
// control, and holds it in the ID/EX register under a valid/ready handshake.
module idu_issue #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_a,
  output logic [XLEN-1:0] ex_b,
  output logic [2:0]      ex_alu_op,
  output logic            ex_sub,
  output logic            ex_slt_signed,
  output logic            ex_slt_unsigned,
  output logic            ex_word,
  output logic [4:0]      ex_rd,
  output logic            ex_wen,
  output logic [XLEN-1:0] ex_pc,
  output logic            ex_illegal
);

  localparam int unsigned IMM_I_W = 12;
  localparam int unsigned IMM_U_W = 32;

  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_OP32    = 7'b0111011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SLL = 3'b001;
  localparam logic [2:0] ALU_XOR = 3'b010;
  localparam logic [2:0] ALU_SRL = 3'b011;
  localparam logic [2:0] ALU_SRA = 3'b100;
  localparam logic [2:0] ALU_OR  = 3'b101;
  localparam logic [2:0] ALU_AND = 3'b110;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] pc;
    logic [2:0]      alu_op;
    logic            sub;
    logic            slt_s;
    logic            slt_u;
    logic            word;
    logic [4:0]      rd;
    logic            wen;
    logic            illegal;
  } ex_t;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rd;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_u;
  logic            is_shift;
  logic            legal;
  logic            wen_raw;
  logic            accept;
  ex_t             dec_d;
  ex_t             ex_q;
  logic            ex_valid_d;
  logic            ex_valid_q;

  assign opcode = in_inst[6:0];
  assign rd     = in_inst[11:7];
  assign funct3 = in_inst[14:12];
  assign funct7 = in_inst[31:25];

  assign imm_i = {{(XLEN-IMM_I_W){in_inst[31]}}, in_inst[31:20]};
  assign imm_s = {{(XLEN-IMM_I_W){in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign imm_u = {{(XLEN-IMM_U_W){in_inst[31]}}, in_inst[31:12], 12'b0};

  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  // funct3 to ALU op; SLT/SLTU compare through the adder
  function automatic logic [2:0] alu_sel(input logic [2:0] f3, input logic arith);
    logic [2:0] op;
    case (f3)
      3'b001:  op = ALU_SLL;
      3'b100:  op = ALU_XOR;
      3'b101:  op = arith ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  // Combinational decode; anything not legal collapses to an all-zero word with illegal set
  always_comb begin
    dec_d   = '0;
    legal   = 1'b1;
    wen_raw = 1'b0;
    case (opcode)
      OPC_OP, OPC_OP32: begin
        dec_d.word = (opcode == OPC_OP32);
        legal = (funct7 == F7_BASE) ||
                ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
        if (dec_d.word && !((funct3 == 3'b000) || is_shift)) legal = 1'b0;
        dec_d.a      = rs1_data;
        dec_d.b      = rs2_data;
        dec_d.alu_op = alu_sel(funct3, in_inst[30]);
        dec_d.sub    = (funct3 == 3'b000) && in_inst[30];
        dec_d.slt_s  = (funct3 == 3'b010);
        dec_d.slt_u  = (funct3 == 3'b011);
        wen_raw      = 1'b1;
      end
      OPC_OPIMM, OPC_OPIMM32: begin
        dec_d.word = (opcode == OPC_OPIMM32);
        if (funct3 == 3'b001) begin
          legal = dec_d.word ? (funct7 == F7_BASE) : (in_inst[31:26] == 6'b000000);
        end else if (funct3 == 3'b101) begin
          legal = dec_d.word ? ((funct7 == F7_BASE) || (funct7 == F7_ALT))
                             : ((in_inst[31:26] == 6'b000000) || (in_inst[31:26] == 6'b010000));
        end else begin
          legal = !dec_d.word || (funct3 == 3'b000);
        end
        dec_d.a = rs1_data;
        if (is_shift) begin
          dec_d.b = dec_d.word ? XLEN'(in_inst[24:20]) : XLEN'(in_inst[25:20]);
        end else begin
          dec_d.b = imm_i;
        end
        dec_d.alu_op = alu_sel(funct3, in_inst[30]);
        dec_d.slt_s  = (funct3 == 3'b010);
        dec_d.slt_u  = (funct3 == 3'b011);
        wen_raw      = 1'b1;
      end
      OPC_LUI: begin
        dec_d.b = imm_u;
        wen_raw = 1'b1;
      end
      OPC_AUIPC: begin
        dec_d.a = in_pc;
        dec_d.b = imm_u;
        wen_raw = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        if ((opcode == OPC_JALR) && (funct3 != 3'b000)) legal = 1'b0;
        dec_d.a = in_pc;
        dec_d.b = XLEN'(4);
        wen_raw = 1'b1;
      end
      OPC_LOAD: begin
        legal   = (funct3 != 3'b111);
        dec_d.a = rs1_data;
        dec_d.b = imm_i;
        wen_raw = 1'b1;
      end
      OPC_STORE: begin
        legal   = (funct3[2] == 1'b0);
        dec_d.a = rs1_data;
        dec_d.b = imm_s;
      end
      OPC_BRANCH: begin
        legal       = (funct3 != 3'b010) && (funct3 != 3'b011);
        dec_d.a     = rs1_data;
        dec_d.b     = rs2_data;
        dec_d.sub   = (funct3[2:1] == 2'b00);
        dec_d.slt_s = (funct3[2:1] == 2'b10);
        dec_d.slt_u = (funct3[2:1] == 2'b11);
      end
      default: legal = 1'b0;
    endcase
    dec_d.rd  = rd;
    dec_d.wen = wen_raw && (rd != 5'd0);
    if (!legal) begin
      dec_d         = '0;
      dec_d.illegal = 1'b1;
    end
    dec_d.pc = in_pc;
  end

  // Handshake: flush kills both the held and the incoming instruction
  assign in_ready = ~ex_valid_q | ex_ready;
  assign accept   = in_valid & in_ready & ~flush;

  always_comb begin
    ex_valid_d = ex_valid_q;
    if (flush) begin
      ex_valid_d = 1'b0;
    end else if (in_ready) begin
      ex_valid_d = in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q <= 1'b0;
      ex_q       <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      if (accept) ex_q <= dec_d;
    end
  end

  assign ex_valid        = ex_valid_q;
  assign ex_a            = ex_q.a;
  assign ex_b            = ex_q.b;
  assign ex_alu_op       = ex_q.alu_op;
  assign ex_sub          = ex_q.sub;
  assign ex_slt_signed   = ex_q.slt_s;
  assign ex_slt_unsigned = ex_q.slt_u;
  assign ex_word         = ex_q.word;
  assign ex_rd           = ex_q.rd;
  assign ex_wen          = ex_q.wen;
  assign ex_pc           = ex_q.pc;
  assign ex_illegal      = ex_q.illegal;

endmodule

// File: tb/tb_idu_issue.sv
// Directed bench for idu_issue: decode vectors with hand-computed operands,
// then back-pressure, flush and mid-stall reset behaviour.
module tb_idu_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [63:0] in_pc;
  logic [63:0] rs1_data;
  logic [63:0] rs2_data;
  logic        flush;
  logic        ex_valid;
  logic        ex_ready;
  logic [63:0] ex_a;
  logic [63:0] ex_b;
  logic [2:0]  ex_alu_op;
  logic        ex_sub;
  logic        ex_slt_signed;
  logic        ex_slt_unsigned;
  logic        ex_word;
  logic [4:0]  ex_rd;
  logic        ex_wen;
  logic [63:0] ex_pc;
  logic        ex_illegal;

  int n_checks = 0;
  int n_errors = 0;

  idu_issue dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_inst         (in_inst),
    .in_pc           (in_pc),
    .rs1_data        (rs1_data),
    .rs2_data        (rs2_data),
    .flush           (flush),
    .ex_valid        (ex_valid),
    .ex_ready        (ex_ready),
    .ex_a            (ex_a),
    .ex_b            (ex_b),
    .ex_alu_op       (ex_alu_op),
    .ex_sub          (ex_sub),
    .ex_slt_signed   (ex_slt_signed),
    .ex_slt_unsigned (ex_slt_unsigned),
    .ex_word         (ex_word),
    .ex_rd           (ex_rd),
    .ex_wen          (ex_wen),
    .ex_pc           (ex_pc),
    .ex_illegal      (ex_illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] inst, input logic [63:0] pc,
                       input logic [63:0] r1, input logic [63:0] r2);
    in_valid = 1'b1;
    in_inst  = inst;
    in_pc    = pc;
    rs1_data = r1;
    rs2_data = r2;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; ex_ready = 1'b1;
    in_inst = 32'h0; in_pc = 64'h0; rs1_data = 64'h0; rs2_data = 64'h0;
    step(); step();
    rst = 1'b0;
    check("rst_valid", 64'(ex_valid), 64'd0);
    check("rst_a", ex_a, 64'd0);
    check("rst_ready", 64'(in_ready), 64'd1);

    // addi x1,x0,5
    drive(32'h00500093, 64'h1000, 64'h0, 64'h77);
    step();
    check("addi_valid", 64'(ex_valid), 64'd1);
    check("addi_a", ex_a, 64'd0);
    check("addi_b", ex_b, 64'd5);
    check("addi_op", 64'(ex_alu_op), 64'd0);
    check("addi_sub", 64'(ex_sub), 64'd0);
    check("addi_rd", 64'(ex_rd), 64'd1);
    check("addi_wen", 64'(ex_wen), 64'd1);
    check("addi_pc", ex_pc, 64'h1000);

    // sub x3,x1,x2
    drive(32'h402081B3, 64'h1004, 64'h10, 64'h3);
    step();
    check("sub_op", 64'(ex_alu_op), 64'd0);
    check("sub_sub", 64'(ex_sub), 64'd1);
    check("sub_a", ex_a, 64'h10);
    check("sub_b", ex_b, 64'h3);
    check("sub_rd", 64'(ex_rd), 64'd3);

    // sltiu x5,x1,-1
    drive(32'hFFF0B293, 64'h1008, 64'h20, 64'h0);
    step();
    check("sltiu_b", ex_b, 64'hFFFF_FFFF_FFFF_FFFF);
    check("sltiu_u", 64'(ex_slt_unsigned), 64'd1);
    check("sltiu_s", 64'(ex_slt_signed), 64'd0);
    check("sltiu_sub", 64'(ex_sub), 64'd0);
    check("sltiu_op", 64'(ex_alu_op), 64'd0);

    // srai x2,x1,63
    drive(32'h43F0D113, 64'h100C, 64'h20, 64'h0);
    step();
    check("srai_op", 64'(ex_alu_op), 64'd4);
    check("srai_b", ex_b, 64'd63);
    check("srai_sub", 64'(ex_sub), 64'd0);

    // lui x1,0x12345
    drive(32'h123450B7, 64'h1010, 64'h55, 64'h66);
    step();
    check("lui_a", ex_a, 64'd0);
    check("lui_b", ex_b, 64'h0000_0000_1234_5000);
    check("lui_wen", 64'(ex_wen), 64'd1);

    // unknown opcode 0x7F
    drive(32'h0000007F, 64'h1014, 64'h55, 64'h66);
    step();
    check("ill_flag", 64'(ex_illegal), 64'd1);
    check("ill_wen", 64'(ex_wen), 64'd0);
    check("ill_a", ex_a, 64'd0);
    check("ill_valid", 64'(ex_valid), 64'd1);

    // or x4,x1,x2
    drive(32'h0020E233, 64'h1018, 64'hF0, 64'h0F);
    step();
    check("or_op", 64'(ex_alu_op), 64'd5);
    check("or_ill", 64'(ex_illegal), 64'd0);

    // blt x1,x2,0
    drive(32'h0020C063, 64'h101C, 64'hAA, 64'hBB);
    step();
    check("blt_slts", 64'(ex_slt_signed), 64'd1);
    check("blt_sub", 64'(ex_sub), 64'd0);
    check("blt_wen", 64'(ex_wen), 64'd0);
    check("blt_b", ex_b, 64'hBB);

    // jal x1,0
    drive(32'h000000EF, 64'h2000, 64'h0, 64'h0);
    step();
    check("jal_a", ex_a, 64'h2000);
    check("jal_b", ex_b, 64'd4);
    check("jal_wen", 64'(ex_wen), 64'd1);

    // addw x7,x1,x2
    drive(32'h002083BB, 64'h2004, 64'h1, 64'h2);
    step();
    check("addw_word", 64'(ex_word), 64'd1);
    check("addw_rd", 64'(ex_rd), 64'd7);

    // slliw with shamt[5] set is illegal
    drive(32'h0210909B, 64'h2008, 64'h1, 64'h2);
    step();
    check("slliw_ill", 64'(ex_illegal), 64'd1);

    // Back-pressure: A (addi x9,x0,9) held while B (addi x10,x0,10) waits
    drive(32'h00900493, 64'h3000, 64'h0, 64'h0);
    step();
    ex_ready = 1'b0;
    drive(32'h00A00513, 64'h3004, 64'h0, 64'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_ready", 64'(in_ready), 64'd0);
      check("bp_rd", 64'(ex_rd), 64'd9);
      check("bp_b", ex_b, 64'd9);
      check("bp_pc", ex_pc, 64'h3000);
    end
    ex_ready = 1'b1;
    step();
    check("bp_next_rd", 64'(ex_rd), 64'd10);
    check("bp_next_pc", ex_pc, 64'h3004);
    in_valid = 1'b0;
    step();
    check("bp_drain", 64'(ex_valid), 64'd0);

    // Flush while stalled with an incoming instruction
    drive(32'h00C00613, 64'h4000, 64'h0, 64'h0);
    step();
    ex_ready = 1'b0; flush = 1'b1;
    drive(32'h00D00693, 64'h4004, 64'h0, 64'h0);
    step();
    check("flush_stall_valid", 64'(ex_valid), 64'd0);
    flush = 1'b0; in_valid = 1'b0; ex_ready = 1'b1;
    step();
    check("flush_stall_after", 64'(ex_valid), 64'd0);

    // Flush with in_ready high: incoming must be dropped, not loaded
    drive(32'h00C00613, 64'h4008, 64'h0, 64'h0);
    step();
    flush = 1'b1;
    drive(32'h00D00693, 64'h400C, 64'h0, 64'h0);
    step();
    check("flush_valid", 64'(ex_valid), 64'd0);
    check("flush_rd_kept", 64'(ex_rd), 64'd12);
    flush = 1'b0; in_valid = 1'b0;
    step();
    check("flush_dropped", 64'(ex_valid), 64'd0);

    // Reset in the middle of a stall
    drive(32'h00E00713, 64'h5000, 64'h0, 64'h0);
    step();
    ex_ready = 1'b0;
    drive(32'h00F00793, 64'h5004, 64'h0, 64'h0);
    step();
    check("stall_valid", 64'(ex_valid), 64'd1);
    rst = 1'b1;
    step();
    check("mrst_valid", 64'(ex_valid), 64'd0);
    check("mrst_b", ex_b, 64'd0);
    check("mrst_rd", 64'(ex_rd), 64'd0);
    check("mrst_wen", 64'(ex_wen), 64'd0);
    check("mrst_pc", ex_pc, 64'd0);
    check("mrst_ready", 64'(in_ready), 64'd1);
    rst = 1'b0; in_valid = 1'b0; ex_ready = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/idu_issue.md
# idu_issue

Decode-and-issue stage feeding the execute unit: takes a fetched 32-bit RV64I instruction with its PC and register-file read data, and produces the operand pair and ALU control word consumed by the EXU. It holds one ID/EX pipeline register with a valid/ready handshake on both sides, so upstream back-pressure and pipeline flushes are handled at this boundary. It sits between fetch/regfile read and the EXU in the five-stage pipeline.

## Interface
- XLEN, 64, datapath width (matches `WIDTH`)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  decode input holds a valid instruction
- in_ready  out  1  stage accepts input this cycle
- in_inst  in  32  instruction word
- in_pc  in  64  instruction PC
- rs1_data, rs2_data  in  64 each  register-file read data (x0 reads as 0 upstream)
- flush  in  1  kill held and incoming instruction
- ex_valid  out  1  ID/EX register holds a valid instruction
- ex_ready  in  1  EXU consumes ID/EX contents this cycle
- ex_a, ex_b  out  64 each  ALU operands a, b
- ex_alu_op  out  3  000 ADD, 001 SLL, 010 XOR, 011 SRL, 100 SRA, 101 OR, 110 AND, 111 unused
- ex_sub  out  1  subtract
- ex_slt_signed, ex_slt_unsigned  out  1 each  set-less-than select
- ex_word  out  1  OP-32/OP-IMM-32; downstream sign-extends low 32 bits
- ex_rd  out  5  destination register
- ex_wen  out  1  writes rd (forced 0 when rd==0)
- ex_pc  out  64  PC of held instruction
- ex_illegal  out  1  unsupported opcode/funct combination

## Operation
- Combinational decode of in_inst; result captured into ID/EX register on accept.
- Immediates sign-extended to 64: I (inst[31:20]), S, B, U ({inst[31:12],12'b0} sign-extended), J.
- OP (0110011) / OP-32: a=rs1, b=rs2; funct3 000 ADD (sub = inst[30]), 001 SLL, 010 ADD+slt_signed, 011 ADD+slt_unsigned, 100 XOR, 101 SRL/SRA by inst[30], 110 OR, 111 AND. funct7 other than 0000000/0100000 (0100000 only with 000/101) → illegal.
- OP-IMM / OP-IMM-32: b=I-imm; shifts use shamt inst[25:20] (inst[24:20] for -32, inst[25]=1 → illegal); SRAI when inst[30]; sub never set.
- Exactly one of sub/slt_signed/slt_unsigned set at most; for SLT, alu_op=ADD.
- LUI: a=0, b=U-imm, ADD. AUIPC: a=pc, b=U-imm. JAL/JALR: a=pc, b=4, ADD, wen=1.
- LOAD/STORE: a=rs1, b=I-/S-imm, ADD; store and BRANCH have wen=0. BRANCH: a=rs1, b=rs2, ADD with sub=1 for BEQ/BNE, slt_signed for BLT/BGE, slt_unsigned for BLTU/BGEU.
- Any other opcode: illegal=1, wen=0, operands/controls 0; still issued (EXU-side trap handling).

## Timing
- in_ready = ~ex_valid | ex_ready (combinational, no dependence on in_valid).
- Accept when in_valid & in_ready: ID/EX loads all fields next edge, ex_valid=1.
- ex_valid & ~ex_ready: all ex_* held stable, in_ready=0.
- ex_valid & ex_ready & ~in_valid: ex_valid→0 next edge; data fields may hold stale values.
- flush: ex_valid→0 next edge; incoming instruction dropped even if in_valid&in_ready. Priority rst > flush > load.
- rst: ex_valid=0 and every ex_* output = 0 on the next edge; in_ready=1 after reset.
- Latency: one cycle input → ex_*. Throughput one instruction/cycle with ex_ready held high.

## Test plan
- Reset then 0x00500093 (addi x1,x0,5), rs1_data=0 → next cycle ex_a=0, ex_b=5, alu_op=000, sub=0, rd=1, wen=1, ex_valid=1.
- 0x402081B3 (sub x3,x1,x2) → alu_op=000, sub=1, a=rs1_data, b=rs2_data, rd=3.
- 0xFFF0B293 (sltiu x5,x1,-1) → b=0xFFFFFFFFFFFFFFFF, slt_unsigned=1, slt_signed=0, sub=0; 0x43F0D113 (srai x2,x1,63) → alu_op=100, b=63.
- 0x123450B7 (lui x1,0x12345) → a=0, b=0x0000000012345000; opcode 0x7F → illegal=1, wen=0.
- Back-pressure: ex_ready=0 for 3 cycles with in_valid=1 → in_ready=0, ex_* unchanged; ex_ready=1 → next instruction loads next edge, none lost or duplicated.
- flush asserted with held and incoming instruction valid → ex_valid=0 next cycle, incoming dropped; rst mid-stall → all ex_* 0, in_ready=1.
